// File: rtl/gps_ack_corr_if.sv
// Bus between the acquisition search controller (master) and the gps_ack_corr correlator (slave).
interface gps_ack_corr_if #(
  parameter int ACC_W = 16,
  parameter int NCO_W = 32,
  parameter int LEN_W = 16
) ();
  logic                    start;
  logic [5:0]              satelite;
  logic [9:0]              chip_delay;
  logic [NCO_W-1:0]        doppler;
  logic [NCO_W-1:0]        code_step;
  logic [LEN_W-1:0]        dump_len;
  logic                    sample_valid;
  logic                    i_sample;
  logic                    busy;
  logic                    done;
  logic                    err;
  logic signed [ACC_W-1:0] acc_i;
  logic signed [ACC_W-1:0] acc_q;

  modport master (
    output start, satelite, chip_delay, doppler, code_step, dump_len, sample_valid, i_sample,
    input  busy, done, err, acc_i, acc_q
  );

  modport slave (
    input  start, satelite, chip_delay, doppler, code_step, dump_len, sample_valid, i_sample,
    output busy, done, err, acc_i, acc_q
  );
endinterface

// File: rtl/gps_ack_corr.sv
// Single-channel GPS L1 C/A acquisition correlator: PRN code generator, code slew, Doppler wipe-off, I/Q integrate-and-dump.
// Optional GPS_ACK_SAT_EN: saturate acc_i/acc_q instead of wrapping.
module gps_ack_corr #(
  parameter int ACC_W = 16,
  parameter int NCO_W = 32,
  parameter int LEN_W = 16
) (
  input logic           clk,
  input logic           rst,
  gps_ack_corr_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SEEK, INTEG, DONE} state_t;

  // G2 phase-select tap pairs {T0,T1} for PRN 1..32
  localparam logic [7:0] TAP_TBL [0:31] = '{
    8'h26, 8'h37, 8'h48, 8'h59, 8'h19, 8'h2A, 8'h18, 8'h29,
    8'h3A, 8'h23, 8'h34, 8'h56, 8'h67, 8'h78, 8'h89, 8'h9A,
    8'h14, 8'h25, 8'h36, 8'h47, 8'h58, 8'h69, 8'h13, 8'h46,
    8'h57, 8'h68, 8'h79, 8'h8A, 8'h16, 8'h27, 8'h38, 8'h49
  };

  state_t                  state, state_nx;
  logic [7:0]              tap_sel;
  logic [3:0]              t0_q, t1_q;
  logic [1:10]             g1, g2;
  logic [9:0]              chip_cnt, seek_cnt;
  logic [NCO_W-1:0]        dop_q, cstep_q, cphase, code_ph;
  logic [NCO_W:0]          code_sum;
  logic [LEN_W-1:0]        len_q, smp_cnt;
  logic signed [ACC_W-1:0] sum_i, sum_q, out_i, out_q;
  logic                    prn_ok, accept, advance, consume, err_q;
  logic                    code_bit, cos_neg, sin_neg, neg_i, neg_q, last_smp;

  function automatic logic signed [ACC_W-1:0] bump(input logic signed [ACC_W-1:0] s, input logic neg);
`ifdef GPS_ACK_SAT_EN
    logic signed [ACC_W-1:0] acc_max, acc_min;
    acc_max = {1'b0, {(ACC_W-1){1'b1}}};
    acc_min = {1'b1, {(ACC_W-1){1'b0}}};
    if (neg) return (s == acc_min) ? s : s - ACC_W'(1);
    else     return (s == acc_max) ? s : s + ACC_W'(1);
`else
    return neg ? s - ACC_W'(1) : s + ACC_W'(1);
`endif
  endfunction

  assign prn_ok   = (bus.satelite != 6'd0) && (bus.satelite <= 6'd32);
  assign tap_sel  = TAP_TBL[5'(bus.satelite - 6'd1)];
  assign code_bit = g1[10] ^ g2[t0_q] ^ g2[t1_q];
  assign cos_neg  = cphase[NCO_W-1] ^ cphase[NCO_W-2];
  assign sin_neg  = cphase[NCO_W-1];
  assign neg_i    = bus.i_sample ^ code_bit ^ cos_neg;
  assign neg_q    = bus.i_sample ^ code_bit ^ sin_neg;
  assign code_sum = {1'b0, code_ph} + {1'b0, cstep_q};
  assign last_smp = (smp_cnt == len_q - LEN_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    advance  = 1'b0;
    consume  = 1'b0;
    case (state)
      IDLE:
        if (bus.start && prn_ok) begin
          accept   = 1'b1;
          state_nx = (bus.chip_delay == 10'd0) ? INTEG : SEEK;
        end
      SEEK: begin
        advance = 1'b1;
        if (seek_cnt == 10'd1) state_nx = INTEG;
      end
      INTEG:
        if (len_q == '0) state_nx = DONE;
        else if (bus.sample_valid) begin
          consume = 1'b1;
          advance = code_sum[NCO_W];
          if (last_smp) state_nx = DONE;
        end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t0_q     <= '0;
      t1_q     <= '0;
      g1       <= '1;
      g2       <= '1;
      chip_cnt <= '0;
      seek_cnt <= '0;
      dop_q    <= '0;
      cstep_q  <= '0;
      cphase   <= '0;
      code_ph  <= '0;
      len_q    <= '0;
      smp_cnt  <= '0;
      sum_i    <= '0;
      sum_q    <= '0;
      out_i    <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= (state == IDLE) && bus.start && !prn_ok;
      if (accept) begin
        t0_q     <= tap_sel[7:4];
        t1_q     <= tap_sel[3:0];
        g1       <= '1;
        g2       <= '1;
        chip_cnt <= '0;
        seek_cnt <= bus.chip_delay;
        dop_q    <= bus.doppler;
        cstep_q  <= bus.code_step;
        len_q    <= bus.dump_len;
        smp_cnt  <= '0;
        cphase   <= '0;
        code_ph  <= '0;
        sum_i    <= '0;
        sum_q    <= '0;
      end
      // Chip 1022 -> 0 reseeds both registers so the 1023-chip epoch is always restarted cleanly
      if (advance) begin
        if (chip_cnt == 10'd1022) begin
          chip_cnt <= '0;
          g1       <= '1;
          g2       <= '1;
        end else begin
          chip_cnt <= chip_cnt + 10'd1;
          g1       <= {g1[3] ^ g1[10], g1[1:9]};
          g2       <= {g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10], g2[1:9]};
        end
      end
      if (state == SEEK) seek_cnt <= seek_cnt - 10'd1;
      if (consume) begin
        sum_i   <= bump(sum_i, neg_i);
        sum_q   <= bump(sum_q, neg_q);
        cphase  <= cphase + dop_q;
        code_ph <= code_sum[NCO_W-1:0];
        smp_cnt <= smp_cnt + LEN_W'(1);
      end
      if (state == DONE) begin
        out_i   <= sum_i;
        out_q   <= sum_q;
        sum_i   <= '0;
        sum_q   <= '0;
        cphase  <= '0;
        code_ph <= '0;
      end
    end
  end

  // During DONE the live sums are presented so results are valid in the same cycle as done
  assign bus.busy  = (state != IDLE);
  assign bus.done  = (state == DONE);
  assign bus.err   = err_q;
  assign bus.acc_i = (state == DONE) ? sum_i : out_i;
  assign bus.acc_q = (state == DONE) ? sum_q : out_q;

endmodule

// File: doc/gps_ack_corr.md
Name: gps_ack_corr

Overview:
- Parametrised single-channel GPS L1 C/A acquisition correlator; successor to the PRN tap-select acquisition front end.
- Generates the C/A code for a selected PRN and slews it by a programmed chip delay.
- Wipes off the carrier with a Doppler NCO, then integrates 1-bit samples into I and Q accumulators over a programmable dump length.
- Sits between the sample front end and the acquisition search controller, which sweeps satelite/chip_delay/doppler and reads acc_i/acc_q on done.

Parameters:
- ACC_W, 16, signed accumulator width for acc_i/acc_q (min 4).
- NCO_W, 32, width of the code and carrier NCO phase accumulators and step words.
- LEN_W, 16, width of dump_len.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle request to begin a correlation; sampled in IDLE only
- satelite  in  6  PRN 1..32; other values are invalid
- chip_delay  in  10  code phase slew in chips, 0..1023
- doppler  in  NCO_W  carrier NCO step per valid sample (two's-complement, wraps)
- code_step  in  NCO_W  code NCO step per valid sample; a chip advances on carry-out
- dump_len  in  LEN_W  number of valid samples to integrate
- sample_valid  in  1  i_sample qualifier
- i_sample  in  1  sign sample: 0 = +1, 1 = -1
- busy  out  1  high from accepted start until DONE inclusive
- done  out  1  one-cycle pulse; acc_i/acc_q valid from this cycle
- err  out  1  one-cycle pulse on start with invalid PRN
- acc_i  out  ACC_W  signed in-phase correlation sum, held until next DONE
- acc_q  out  ACC_W  signed quadrature correlation sum, held until next DONE

Behaviour:
- Reset: state IDLE; busy/done/err=0; acc_i/acc_q=0; G1/G2=all ones; NCO phases, chip and sample counters=0.
- Inputs are latched on the start-accept edge; later changes have no effect until the next start.
- Code generator:
  - G1 = 1+x^3+x^10; G2 = 1+x^2+x^3+x^6+x^8+x^9+x^10; both seeded all ones on every accepted start.
  - Code bit = G1[10] ^ G2[T0] ^ G2[T1], using the standard IS-GPS-200 phase-select pairs for PRN 1..32 (PRN1 = 2,6 ... PRN32 = 4,9).
  - A 10-bit chip counter wraps 1022->0 and reseeds both registers at the wrap.
  - PRN1 first ten chips: 1100100000.
- FSM:
  - IDLE: on start with PRN 1..32, go to SEEK (busy=1). On start with invalid PRN, err=1 for one cycle and stay in IDLE.
  - SEEK: advance the code by one chip per clk for chip_delay cycles. chip_delay=0 goes directly to INTEG the next cycle; 1023 returns to chip 0. sample_valid is ignored in SEEK.
  - INTEG: on each sample_valid:
    - cos_neg = cphase[MSB]^cphase[MSB-1]; sin_neg = cphase[MSB].
    - acc_i += (i_sample^code^cos_neg) ? -1 : +1; acc_q += (i_sample^code^sin_neg) ? -1 : +1.
    - Both carrier signs use the phase before the update; the carrier NCO then adds doppler.
    - The code NCO adds code_step; on carry-out the code advances one chip after this sample.
    - After dump_len samples have been consumed, go to DONE. dump_len=0 goes straight to DONE with zero sums.
  - DONE: one cycle; done=1; outputs load the internal sums; internal sums and NCO phases clear; then IDLE (busy=0 next cycle).
- Overflow: without GPS_ACK_SAT_EN, the sums wrap modulo 2^ACC_W.
- start while busy: ignored.
- Reset mid-operation: immediate return to reset values; no done pulse.

Optional Feature:
- Macro GPS_ACK_SAT_EN.
- Defined: acc_i and acc_q each saturate independently at +(2^(ACC_W-1)-1) and -(2^(ACC_W-1)).
- Undefined: the sums wrap; the saturation logic is absent.

Test Plan:
- PRN1, chip_delay=0, doppler=0, code_step=0x8000_0000, dump_len=2046, samples = model code (2 per chip), continuous valid -> done after 2046 samples; acc_i=2046, acc_q=2046.
- PRN7, samples from the model delayed 5 chips, chip_delay=5, same setup -> acc_i=2046; with chip_delay=6, |acc_i| <= 130.
- ACC_W=8, matched PRN1, dump_len=300 -> acc_i=127 with GPS_ACK_SAT_EN; acc_i=44 without.
- satelite=0 then satelite=33, each with start -> err pulse each time; busy stays 0; acc_i/acc_q unchanged.
- PRN3, doppler=0x4000_0000, code_step=0x8000_0000, dump_len=4, all samples = code -> carrier quadrants 0,1,2,3 give acc_i=0, acc_q=0.
- Assert rst for 1 cycle mid-INTEG -> busy=0, acc_i/acc_q=0, no done pulse; next matched PRN1 run gives acc_i=2046.
